// File: rtl/game_pkg.sv
// Shared types for the penalty-shootout match sequencer and its control bundle.
package game_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned ROUND_W = 4;

  typedef enum logic [2:0] {
    START   = 3'd0,
    KEEPER  = 3'd1,
    SHOOTER = 3'd2,
    WINNER  = 3'd3,
    LOOSER  = 3'd4
  } g_state_t;

  typedef enum logic {
    SOLO  = 1'b0,
    MULTI = 1'b1
  } g_mode_t;

  // Bundle consumed by screen selection, drawing and text blocks.
  typedef struct packed {
    g_state_t                 game_state;
    g_mode_t                  game_mode;
    logic [2*SCORE_W-1:0]     score;          // {opp, player}
    logic [ROUND_W-1:0]       round_counter;
    logic                     is_scored;
  } control_t;

  // Increment by en, holding at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic en);
    if (en && (v != '1)) return v + SCORE_W'(1);
    return v;
  endfunction

endpackage

// File: rtl/result_timer.sv
// Result hold timer: counts RESULT_CYCLES after a start pulse; done_c marks the final cycle.
module result_timer #(
  parameter int unsigned RESULT_CYCLES = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done_c
);

  localparam int unsigned CNT_W = $clog2(RESULT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  assign done_c = (cnt == CNT_W'(1));

  // Down-counter loaded on start, idles at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(RESULT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Busy flag mirrors a non-zero count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
    end else if (done_c) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/game_fsm.sv
// Penalty-shootout match sequencer driving the control bundle.
// Optional macro GAME_SUDDEN_DEATH_EN: ties after regulation continue into sudden death.
module game_fsm
  import game_pkg::*;
#(
  parameter int unsigned ROUNDS        = 5,
  parameter int unsigned RESULT_CYCLES = 65_000_000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start_req,
  input  logic     mode_sel,
  input  logic     shot_valid,
  input  logic     shot_goal,
  input  logic     restart_req,
  output control_t out_control
);

  localparam logic [ROUND_W-1:0] ROUNDS_C = ROUND_W'(ROUNDS);
  localparam logic [ROUND_W-1:0] ROUND_MAX = '1;

  g_state_t            state, state_n;
  g_mode_t             mode, mode_n;
  logic [SCORE_W-1:0]  p_score, p_score_n, o_score, o_score_n;
  logic [ROUND_W-1:0]  rounds, rounds_n, rounds_inc;
  logic                is_scored, is_scored_n;
  logic                timer_start, timer_busy, timer_done;

  result_timer #(.RESULT_CYCLES(RESULT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (timer_start),
    .busy   (timer_busy),
    .done_c (timer_done)
  );

  // State and bundle registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= START;
      mode      <= MULTI;
      p_score   <= '0;
      o_score   <= '0;
      rounds    <= '0;
      is_scored <= 1'b0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      p_score   <= p_score_n;
      o_score   <= o_score_n;
      rounds    <= rounds_n;
      is_scored <= is_scored_n;
    end
  end

  // Next-state, scoring and hold control.
  always_comb begin
    state_n     = state;
    mode_n      = mode;
    p_score_n   = p_score;
    o_score_n   = o_score;
    rounds_n    = rounds;
    is_scored_n = is_scored;
    timer_start = 1'b0;
    rounds_inc  = ROUND_W'(sat_inc(SCORE_W'(rounds), 1'b1));

    case (state)
      START: begin
        if (start_req) begin
          state_n     = SHOOTER;
          mode_n      = g_mode_t'(mode_sel);
          p_score_n   = '0;
          o_score_n   = '0;
          rounds_n    = '0;
          is_scored_n = 1'b0;
        end
      end
      SHOOTER: begin
        if (timer_busy) begin
          if (timer_done) begin
            is_scored_n = 1'b0;
            state_n     = KEEPER;
          end
        end else if (shot_valid) begin
          is_scored_n = shot_goal;
          p_score_n   = sat_inc(p_score, shot_goal);
          timer_start = 1'b1;
        end
      end
      KEEPER: begin
        if (timer_busy) begin
          if (timer_done) begin
            is_scored_n = 1'b0;
            rounds_n    = rounds_inc;
            if (rounds_inc < ROUNDS_C) begin
              state_n = SHOOTER;
            end else if (p_score > o_score) begin
              state_n = WINNER;
            end else if (p_score < o_score) begin
              state_n = LOOSER;
            end else begin
`ifdef GAME_SUDDEN_DEATH_EN
              state_n = (rounds_inc == ROUND_MAX) ? LOOSER : SHOOTER;
`else
              state_n = LOOSER;
`endif
            end
          end
        end else if (shot_valid) begin
          is_scored_n = shot_goal;
          o_score_n   = sat_inc(o_score, shot_goal);
          timer_start = 1'b1;
        end
      end
      WINNER, LOOSER: begin
        if (restart_req) begin
          state_n     = START;
          p_score_n   = '0;
          o_score_n   = '0;
          rounds_n    = '0;
          is_scored_n = 1'b0;
        end
      end
      default: state_n = START;
    endcase
  end

  // Bundle is driven straight from registers.
  always_comb begin
    out_control.game_state    = state;
    out_control.game_mode     = mode;
    out_control.score         = {o_score, p_score};
    out_control.round_counter = rounds;
    out_control.is_scored     = is_scored;
  end

endmodule

// File: tb/tb_game_fsm.sv
// Self-checking bench for game_fsm (ROUNDS=5, RESULT_CYCLES=4).
module tb_game_fsm;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst, start_req, mode_sel, shot_valid, shot_goal, restart_req;
  control_t out_control;

  int checks = 0;
  int errors = 0;

  game_fsm #(.ROUNDS(5), .RESULT_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_req   (start_req),
    .mode_sel    (mode_sel),
    .shot_valid  (shot_valid),
    .shot_goal   (shot_goal),
    .restart_req (restart_req),
    .out_control (out_control)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic     rst, sr, ms, sv, sg, rr;
    control_t e;
  } vec_t;

  typedef struct {
    string    name;
    control_t e;
  } sb_t;

  sb_t sbq[$];

  // Transaction-level expectation model
  g_state_t   m_state;
  g_mode_t    m_mode;
  logic [3:0] mp, mo, mrc;
  logic       m_is;

  function automatic control_t mkc(input g_state_t s, input g_mode_t m, input logic [7:0] sc,
                                   input logic [3:0] rc, input logic is);
    control_t c;
    c.game_state = s; c.game_mode = m; c.score = sc; c.round_counter = rc; c.is_scored = is;
    return c;
  endfunction

  function automatic vec_t mkv(input logic r, sr, ms, sv, sg, rr, input control_t e);
    vec_t v;
    v.rst = r; v.sr = sr; v.ms = ms; v.sv = sv; v.sg = sg; v.rr = rr; v.e = e;
    return v;
  endfunction

  function automatic string fmt(input control_t c);
    return $sformatf("st=%0d md=%0d sc=%02h rc=%0d is=%0d", c.game_state, c.game_mode,
                     c.score, c.round_counter, c.is_scored);
  endfunction

  function automatic control_t exp_now();
    return mkc(m_state, m_mode, {mo, mp}, mrc, m_is);
  endfunction

  // One clock: drive inputs, queue expectation, compare after the edge.
  task automatic step(input logic r, sr, ms, sv, sg, rr, input control_t e, input string nm);
    sb_t s;
    @(negedge clk);
    rst = r; start_req = sr; mode_sel = ms; shot_valid = sv; shot_goal = sg; restart_req = rr;
    sbq.push_back('{nm, e});
    @(posedge clk);
    #1;
    s = sbq.pop_front();
    checks++;
    if (out_control !== s.e) begin
      errors++;
      $display("FAIL %s: got %s expected %s", s.name, fmt(out_control), fmt(s.e));
    end
  endtask

  task automatic check_val(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, got, want);
    end
  endtask

  task automatic do_reset();
    m_state = START; m_mode = MULTI; mp = 0; mo = 0; mrc = 0; m_is = 0;
    step(0, 0, 0, 0, 0, 0, exp_now(), "reset");
  endtask

  task automatic start_match(input g_mode_t md);
    m_state = SHOOTER; m_mode = md; mp = 0; mo = 0; mrc = 0; m_is = 0;
    step(1, 1, md, 0, 0, 0, exp_now(), "start");
  endtask

  task automatic restart_match();
    m_state = START; mp = 0; mo = 0; mrc = 0; m_is = 0;
    step(1, 0, 0, 0, 0, 1, exp_now(), "restart");
  endtask

  task automatic frozen();
    step(1, 1, 0, 1, 1, 0, exp_now(), "end_frozen");
  endtask

  task automatic shot(input logic goal);
    if (m_state == SHOOTER) mp = (mp == 4'hF) ? mp : mp + 4'(goal);
    else                    mo = (mo == 4'hF) ? mo : mo + 4'(goal);
    m_is = goal;
    step(1, 0, 0, 1, goal, 0, exp_now(), "shot");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, exp_now(), "hold");
    m_is = 0;
    if (m_state == SHOOTER) begin
      m_state = KEEPER;
    end else begin
      mrc = (mrc == 4'hF) ? mrc : mrc + 4'd1;
      if (mrc < 4'd5)    m_state = SHOOTER;
      else if (mp > mo)  m_state = WINNER;
      else if (mp < mo)  m_state = LOOSER;
      else begin
`ifdef GAME_SUDDEN_DEATH_EN
        m_state = (mrc == 4'hF) ? LOOSER : SHOOTER;
`else
        m_state = LOOSER;
`endif
      end
    end
    step(1, 0, 0, 0, 0, 0, exp_now(), "hold_end");
  endtask

  task automatic play_round(input logic pg, input logic og);
    shot(pg);
    shot(og);
  endtask

  vec_t vecs[26];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; start_req = 0; mode_sel = 0; shot_valid = 0; shot_goal = 0; restart_req = 0;

    vecs[0]  = mkv(0,0,0,0,0,0, mkc(START,   MULTI, 8'h00, 0, 0));
    vecs[1]  = mkv(1,0,0,0,0,0, mkc(START,   MULTI, 8'h00, 0, 0));
    vecs[2]  = mkv(1,0,0,1,1,1, mkc(START,   MULTI, 8'h00, 0, 0));
    vecs[3]  = mkv(1,1,1,0,0,0, mkc(SHOOTER, MULTI, 8'h00, 0, 0));
    vecs[4]  = mkv(1,1,0,0,0,1, mkc(SHOOTER, MULTI, 8'h00, 0, 0));
    vecs[5]  = mkv(1,0,0,1,1,0, mkc(SHOOTER, MULTI, 8'h01, 0, 1));
    vecs[6]  = mkv(1,0,0,0,0,0, mkc(SHOOTER, MULTI, 8'h01, 0, 1));
    vecs[7]  = mkv(1,0,0,1,1,0, mkc(SHOOTER, MULTI, 8'h01, 0, 1));
    vecs[8]  = mkv(1,0,0,0,0,0, mkc(SHOOTER, MULTI, 8'h01, 0, 1));
    vecs[9]  = mkv(1,0,0,0,0,0, mkc(KEEPER,  MULTI, 8'h01, 0, 0));
    vecs[10] = mkv(1,1,0,0,0,0, mkc(KEEPER,  MULTI, 8'h01, 0, 0));
    vecs[11] = mkv(1,0,0,0,0,1, mkc(KEEPER,  MULTI, 8'h01, 0, 0));
    vecs[12] = mkv(1,0,0,1,1,0, mkc(KEEPER,  MULTI, 8'h11, 0, 1));
    vecs[13] = mkv(1,0,0,0,0,0, mkc(KEEPER,  MULTI, 8'h11, 0, 1));
    vecs[14] = mkv(1,0,0,0,0,0, mkc(KEEPER,  MULTI, 8'h11, 0, 1));
    vecs[15] = mkv(1,0,0,0,0,0, mkc(KEEPER,  MULTI, 8'h11, 0, 1));
    vecs[16] = mkv(1,0,0,0,0,0, mkc(SHOOTER, MULTI, 8'h11, 1, 0));
    vecs[17] = mkv(1,0,0,1,0,0, mkc(SHOOTER, MULTI, 8'h11, 1, 0));
    vecs[18] = mkv(1,0,0,0,0,0, mkc(SHOOTER, MULTI, 8'h11, 1, 0));
    vecs[19] = mkv(0,0,0,1,1,0, mkc(START,   MULTI, 8'h00, 0, 0));
    vecs[20] = mkv(1,1,0,0,0,0, mkc(SHOOTER, SOLO,  8'h00, 0, 0));
    vecs[21] = mkv(1,0,0,1,1,0, mkc(SHOOTER, SOLO,  8'h01, 0, 1));
    vecs[22] = mkv(1,0,0,0,0,0, mkc(SHOOTER, SOLO,  8'h01, 0, 1));
    vecs[23] = mkv(1,0,0,0,0,0, mkc(SHOOTER, SOLO,  8'h01, 0, 1));
    vecs[24] = mkv(1,0,0,0,0,0, mkc(SHOOTER, SOLO,  8'h01, 0, 1));
    vecs[25] = mkv(1,0,0,0,0,0, mkc(KEEPER,  SOLO,  8'h01, 0, 0));

    for (int i = 0; i < 26; i++)
      step(vecs[i].rst, vecs[i].sr, vecs[i].ms, vecs[i].sv, vecs[i].sg, vecs[i].rr,
           vecs[i].e, $sformatf("vec%0d", i));

    // Player wins every round in SOLO mode
    do_reset();
    start_match(SOLO);
    for (int r = 0; r < 5; r++) play_round(1'b1, 1'b0);
    check_val("win_score", out_control.score, 8'h05);
    check_val("win_state", 8'(out_control.game_state), 8'(WINNER));
    frozen();
    restart_match();
    check_val("restart_mode", 8'(out_control.game_mode), 8'(SOLO));

    // Player loses every round in MULTI mode
    start_match(MULTI);
    for (int r = 0; r < 5; r++) play_round(1'b0, 1'b1);
    check_val("lose_score", out_control.score, 8'h50);
    check_val("lose_state", 8'(out_control.game_state), 8'(LOOSER));
    frozen();
    restart_match();

    // 3-3 tie after regulation
    start_match(MULTI);
    for (int r = 0; r < 3; r++) play_round(1'b1, 1'b1);
    for (int r = 0; r < 2; r++) play_round(1'b0, 1'b0);
`ifdef GAME_SUDDEN_DEATH_EN
    check_val("tie_state", 8'(out_control.game_state), 8'(SHOOTER));
    play_round(1'b1, 1'b0);
    check_val("sd_score", out_control.score, 8'h34);
    check_val("sd_rounds", 8'(out_control.round_counter), 8'd6);
    check_val("sd_state", 8'(out_control.game_state), 8'(WINNER));
    restart_match();
    start_match(SOLO);
    for (int r = 0; r < 15; r++) play_round(1'b1, 1'b1);
    check_val("sd_cap_state", 8'(out_control.game_state), 8'(LOOSER));
    check_val("sd_cap_score", out_control.score, 8'hFF);
`else
    check_val("tie_state", 8'(out_control.game_state), 8'(LOOSER));
    check_val("tie_score", out_control.score, 8'h33);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_fsm.md
Name: game_fsm

Overview:
- Match sequencer that writes the control_if bundle: game_state, game_mode, score, round_counter, is_scored.
- Screen selection, drawing and text blocks downstream consume this bundle.
- Converts user requests and per-shot outcomes into penalty-shootout progress.
- Produces final WINNER/LOOSER decision.

Parameters:
- ROUNDS, 5, regulation rounds; one round = one player shot + one player save attempt.
- RESULT_CYCLES, 65_000_000, clk cycles a shot result is held before advancing (1 s at 65 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- start_req  in  1  single-cycle pulse, begin match
- mode_sel  in  1  0 = SOLO, 1 = MULTI; sampled with start_req
- shot_valid  in  1  single-cycle pulse, current shot resolved
- shot_goal  in  1  qualifies shot_valid; 1 = ball entered goal
- restart_req  in  1  single-cycle pulse, return to START from an end screen
- out_control.game_state  out  3  g_state_t
- out_control.game_mode  out  1  g_mode_t
- out_control.score  out  8  {opp_score[3:0], player_score[3:0]}
- out_control.round_counter  out  4  completed rounds
- out_control.is_scored  out  1  last resolved shot was a goal; valid during result hold

Behaviour:
- All outputs registered; every update appears one cycle after the causing input.
- Reset (rst=0 at posedge, any state including mid-hold):
  - game_state=START, game_mode=MULTI, score=0, round_counter=0, is_scored=0.
  - Hold timer cleared.
- START:
  - start_req=1 -> SHOOTER.
  - Latch game_mode from mode_sel; clear score, round_counter, is_scored.
  - shot_valid and restart_req ignored.
- SHOOTER (player shoots), on shot_valid:
  - is_scored<=shot_goal; player_score+=shot_goal.
  - Enter hold sub-phase; game_state unchanged.
- KEEPER (player defends), on shot_valid:
  - is_scored<=shot_goal; opp_score+=shot_goal.
  - Enter hold.
- Hold:
  - Counter runs RESULT_CYCLES cycles; shot_valid ignored.
  - Final cycle clears is_scored.
  - SHOOTER -> KEEPER.
  - KEEPER -> round_counter+1, then evaluate.
  - Net effect: first shot_valid accepted again RESULT_CYCLES+1 cycles after the previous one.
- Evaluate (after KEEPER hold, using new round_counter):
  - round_counter < ROUNDS -> SHOOTER.
  - Otherwise player > opp -> WINNER; player < opp -> LOOSER; tie -> see Optional Feature.
  - No early termination when result is mathematically decided.
- WINNER/LOOSER:
  - Outputs frozen.
  - restart_req -> START, clearing score, round_counter, is_scored; game_mode retained.
- Arithmetic: scores and round_counter saturate at 15, never wrap.
- start_req outside START is ignored; restart_req outside WINNER/LOOSER is ignored.
- Simultaneous shot_valid and start_req/restart_req: only the input legal in the current state acts.
- game_state never takes a value outside g_state_t; unreachable encodings recover to START next cycle.

Optional Feature:
- Macro: GAME_SUDDEN_DEATH_EN.
- Defined:
  - Tie after regulation -> SHOOTER; rounds continue.
  - Each later round's KEEPER hold ends with evaluate: unequal -> WINNER/LOOSER.
  - round_counter reaching 15 while tied -> LOOSER.
- Undefined: tie after regulation -> LOOSER immediately.

Decomposition:
- game_pkg holds:
  - g_state_t enum {START, KEEPER, SHOOTER, WINNER, LOOSER}, 3 bits.
  - g_mode_t enum {SOLO, MULTI}.
  - SCORE_W=4 and ROUND_W=4.
- Sub-module result_timer:
  - Ports: clk, rst, start pulse, busy, done pulse.
  - Parameter RESULT_CYCLES; counter width $clog2(RESULT_CYCLES+1).
  - Instantiated once by game_fsm.

Test Plan (RESULT_CYCLES=4, ROUNDS=5):
- Reset mid-hold: rst=0 for one cycle during SHOOTER hold -> next cycle game_state=START, score=0x00, is_scored=0. Then start_req with mode_sel=0 -> SHOOTER, game_mode=SOLO.
- Player wins: 5 rounds, player goal every shot, keeper shots all misses -> score=0x05, round_counter=5, WINNER one cycle after final hold. restart_req -> START, score=0x00.
- Player loses: 5 rounds, player misses all, opponent scores all -> score=0x50, LOOSER. is_scored=1 during each KEEPER hold.
- Hold ignore: second shot_valid (goal) 2 cycles after first during hold -> score unchanged; state advances only after the 4-cycle hold.
- Tie at 3-3 after 5 rounds:
  - Macro undefined -> LOOSER.
  - Macro defined -> SHOOTER. Round 6: player goal, opponent miss -> score=0x34, round_counter=6, WINNER.
- Illegal requests: start_req in KEEPER and restart_req in SHOOTER -> no state or score change.
